// File: rtl/flip_register.sv
`default_nettype none
// ============================================================================
// Module      : flip_register
// Description : WIDTH-bit register with load / toggle / shift-left /
//               shift-right update modes, a registered "changed" pulse and a
//               saturating, clearable count of edges on which Q changed.
// Revision    : 1.0 - initial release
// ============================================================================
module flip_register #(
    parameter int              WIDTH     = 8,
    parameter int              CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             E,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] NotQ,
    output logic             changed,
    output logic [CNT_W-1:0] flip_count
);

    localparam logic [1:0]       c_MODE_LOAD   = 2'b00;
    localparam logic [1:0]       c_MODE_TOGGLE = 2'b01;
    localparam logic [1:0]       c_MODE_SHL    = 2'b10;
    localparam logic [1:0]       c_MODE_SHR    = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_next;
    logic             w_diff;

    // A 1-bit register has no bits to carry over, so both shifts just take sin.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_shl = sin;
            assign w_shr = sin;
        end else begin : g_shift_wn
            assign w_shl = {r_q[WIDTH-2:0], sin};
            assign w_shr = {sin, r_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state selection; Q holds whenever the enable is low.
    always_comb begin
        w_next = r_q;
        if (E) begin
            case (mode)
                c_MODE_LOAD:   w_next = D;
                c_MODE_TOGGLE: w_next = r_q ^ D;
                c_MODE_SHL:    w_next = w_shl;
                c_MODE_SHR:    w_next = w_shr;
                default:       w_next = r_q;
            endcase
        end
    end

    // A change is judged on the value actually stored, so enabled updates
    // that reproduce the current value do not count.
    assign w_diff = (w_next != r_q);

    // State register, change pulse and saturating counter; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_q       <= w_next;
            r_changed <= w_diff;
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if (w_diff && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign Q          = r_q;
    assign NotQ       = ~r_q;
    assign changed    = r_changed;
    assign flip_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flip_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_flip_register
// Description : Directed, scoreboard-checked bench for flip_register. Three
//               instances share stimulus: default 8-bit, an 8-bit one with a
//               2-bit counter and RESET_VAL 0x3C, and a 1-bit one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flip_register;

    typedef struct packed {
        logic [31:0] q;
        logic        ch;
        logic [31:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       e;
    logic [1:0] mode;
    logic       sin;
    logic       clr;

    logic [7:0] qa, nqa, qb, nqb;
    logic [0:0] qc, nqc;
    logic       cha, chb, chc;
    logic [7:0] cnta;
    logic [1:0] cntb;
    logic [3:0] cntc;

    logic [31:0] oq   [3];
    logic [31:0] onq  [3];
    logic        och  [3];
    logic [31:0] ocnt [3];

    int unsigned mw  [3];
    int unsigned mcw [3];
    logic [31:0] mrv [3];
    logic [31:0] mq  [3];
    logic [31:0] mc  [3];

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    int n_assert = 0;
    int n_fail   = 0;
    bit model_valid = 1'b0;

    int exp_cnt_b [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    flip_register #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .D(d), .E(e), .mode(mode), .sin(sin),
        .clr_cnt(clr), .Q(qa), .NotQ(nqa), .changed(cha), .flip_count(cnta)
    );

    flip_register #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'h3C)) dut_b (
        .clk(clk), .rst(rst), .D(d), .E(e), .mode(mode), .sin(sin),
        .clr_cnt(clr), .Q(qb), .NotQ(nqb), .changed(chb), .flip_count(cntb)
    );

    flip_register #(.WIDTH(1), .CNT_W(4), .RESET_VAL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .D(d[0]), .E(e), .mode(mode), .sin(sin),
        .clr_cnt(clr), .Q(qc), .NotQ(nqc), .changed(chc), .flip_count(cntc)
    );

    assign oq[0]   = {24'b0, qa};
    assign oq[1]   = {24'b0, qb};
    assign oq[2]   = {31'b0, qc};
    assign onq[0]  = {24'b0, nqa};
    assign onq[1]  = {24'b0, nqb};
    assign onq[2]  = {31'b0, nqc};
    assign och[0]  = cha;
    assign och[1]  = chb;
    assign och[2]  = chc;
    assign ocnt[0] = {24'b0, cnta};
    assign ocnt[1] = {30'b0, cntb};
    assign ocnt[2] = {28'b0, cntc};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // One clock of stimulus: drive, predict, push, wait for the edge, pop, compare.
    task automatic step(input logic r, input logic en, input logic [1:0] m,
                        input logic s, input logic c, input logic [7:0] dv);
        exp_t        x;
        logic [31:0] msk, dk, nq, cmax;
        rst = r; e = en; mode = m; sin = s; clr = c; d = dv;
        #1;
        if (model_valid) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("hold_between_edges[%0d]", k), oq[k], mq[k]);
        end
        for (int k = 0; k < 3; k++) begin
            msk  = wmask(mw[k]);
            cmax = wmask(mcw[k]);
            dk   = {24'b0, dv} & msk;
            if (r) begin
                x.q = mrv[k]; x.ch = 1'b0; x.cnt = 32'd0;
            end else begin
                nq = mq[k];
                if (en) begin
                    case (m)
                        2'd0: nq = dk;
                        2'd1: nq = mq[k] ^ dk;
                        2'd2: nq = ((mq[k] << 1) | {31'b0, s}) & msk;
                        default: nq = (mq[k] >> 1) | ({31'b0, s} << (mw[k] - 1));
                    endcase
                end
                x.q  = nq;
                x.ch = (nq != mq[k]);
                if (c)                          x.cnt = 32'd0;
                else if (x.ch && mc[k] < cmax)  x.cnt = mc[k] + 32'd1;
                else                            x.cnt = mc[k];
            end
            mq[k] = x.q;
            mc[k] = x.cnt;
            case (k)
                0:       sb0.push_back(x);
                1:       sb1.push_back(x);
                default: sb2.push_back(x);
            endcase
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       x = sb0.pop_front();
                1:       x = sb1.pop_front();
                default: x = sb2.pop_front();
            endcase
            check($sformatf("q[%0d]", k),       oq[k],             x.q);
            check($sformatf("notq[%0d]", k),    onq[k],            ~x.q & wmask(mw[k]));
            check($sformatf("changed[%0d]", k), {31'b0, och[k]},   {31'b0, x.ch});
            check($sformatf("count[%0d]", k),   ocnt[k],           x.cnt);
        end
        model_valid = 1'b1;
    endtask

    // Directed sequence; fixed-value checks restate the expected spec examples.
    initial begin
        mw  = '{8, 8, 1};
        mcw = '{8, 2, 4};
        mrv = '{32'h00, 32'h3C, 32'h0};
        mq  = '{32'h0, 32'h0, 32'h0};
        mc  = '{32'h0, 32'h0, 32'h0};
        rst = 1'b1; d = 8'h00; e = 1'b0; mode = 2'b00; sin = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset overrides enable, mode and clear.
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
        check("rst_q_a", oq[0], 32'h00);
        check("rst_q_b", oq[1], 32'h3C);
        check("rst_cnt_a", ocnt[0], 32'd0);
        check("rst_changed_b", {31'b0, och[1]}, 32'd0);

        // Load, then toggle with a full and an empty mask.
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'hA5);
        check("load_q", oq[0], 32'hA5);
        check("load_notq", onq[0], 32'h5A);
        check("load_changed", {31'b0, och[0]}, 32'd1);
        check("load_cnt", ocnt[0], 32'd1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'hFF);
        check("tog_q", oq[0], 32'h5A);
        check("tog_cnt", ocnt[0], 32'd2);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
        check("tog0_changed", {31'b0, och[0]}, 32'd0);
        check("tog0_cnt", ocnt[0], 32'd2);

        // Load zero while clearing: clear wins over the increment.
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 8'h00);
        check("clr_load_q", oq[0], 32'h00);
        check("clr_load_cnt", ocnt[0], 32'd0);

        // Shift ones in from the right, then one zero in from the left.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h55);
            check($sformatf("shl_q_%0d", i), oq[0], (32'd1 << (i + 1)) - 32'd1);
        end
        check("shl_cnt", ocnt[0], 32'd8);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        check("shr_q", oq[0], 32'h7F);

        // Disabled: everything else toggling, Q must hold.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 2'(i), i[0], 1'b0, (i[0] ? 8'hAA : 8'h55));
            check($sformatf("hold_q_%0d", i), oq[0], 32'h7F);
            check($sformatf("hold_changed_%0d", i), {31'b0, och[0]}, 32'd0);
        end
        check("hold_cnt", ocnt[0], 32'd9);

        // Clear alone, then saturate the 2-bit counter.
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h01);
            check($sformatf("sat_cnt_%0d", i), ocnt[1], 32'(exp_cnt_b[i]));
        end
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'h01);
        check("sat_clr_cnt", ocnt[1], 32'd0);
        check("sat_clr_changed", {31'b0, och[1]}, 32'd1);

        // Reset in the middle of a shift sequence.
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        check("midrst_q", oq[1], 32'h3C);
        check("midrst_changed", {31'b0, och[1]}, 32'd0);
        check("midrst_cnt", ocnt[1], 32'd0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h3C);
        check("post_rst_same_changed", {31'b0, och[1]}, 32'd0);
        check("post_rst_load_changed_a", {31'b0, och[0]}, 32'd1);

        // 1-bit register: both shift directions take sin.
        step(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        check("w1_shl_q", oq[2], 32'd1);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        check("w1_shr_q", oq[2], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
